// File: rtl/riscv_pkg.sv
// Shared encodings for the instruction encoder: ImmSel codes, opcodes, error codes, immediate limits.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package riscv_pkg;

  // Immediate format selector; 101 and 110 are not legal.
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Rejection reasons reported alongside err_o.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_SEL      = 2'b11
  } err_code_e;

  // Signed immediate limits per format.
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  // Decoded fields held in the capture stage.
  typedef struct packed {
    logic [2:0]  imm_sel;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

endpackage

// File: rtl/imm_pack.sv
// Scatters a signed immediate into RV32I bit positions and range/alignment-checks it.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to do with the error code.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  imm_sel_i,
  input  logic [31:0] imm_i,
  output logic [31:0] mask_o,
  output logic [31:0] value_o,
  output err_code_e   err_o
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm_i);

  // Place immediate bits for the selected format and flag illegal values.
  always_comb begin
    mask_o  = '0;
    value_o = '0;
    err_o   = ERR_NONE;
    case (imm_sel_i)
      IMM_I: begin
        mask_o          = 32'hFFF0_0000;
        value_o[31:20]  = imm_i[11:0];
        if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) err_o = ERR_RANGE;
      end
      IMM_S: begin
        mask_o          = 32'hFE00_0F80;
        value_o[31:25]  = imm_i[11:5];
        value_o[11:7]   = imm_i[4:0];
        if (imm_s < IMM_I_MIN || imm_s > IMM_I_MAX) err_o = ERR_RANGE;
      end
      IMM_B: begin
        mask_o          = 32'hFE00_0F80;
        value_o[31]     = imm_i[12];
        value_o[30:25]  = imm_i[10:5];
        value_o[11:8]   = imm_i[4:1];
        value_o[7]      = imm_i[11];
        // Misalignment takes precedence over range.
        if (imm_i[0]) err_o = ERR_MISALIGN;
        else if (imm_s < IMM_B_MIN || imm_s > IMM_B_MAX) err_o = ERR_RANGE;
      end
      IMM_J: begin
        mask_o          = 32'hFFFF_F000;
        value_o[31]     = imm_i[20];
        value_o[30:21]  = imm_i[10:1];
        value_o[20]     = imm_i[11];
        value_o[19:12]  = imm_i[19:12];
        if (imm_i[0]) err_o = ERR_MISALIGN;
        else if (imm_s < IMM_J_MIN || imm_s > IMM_J_MAX) err_o = ERR_RANGE;
      end
      IMM_U: begin
        mask_o          = 32'hFFFF_F000;
        value_o[31:12]  = imm_i[31:12];
        // Low 12 bits cannot be represented in a U-type word.
        if (imm_i[11:0] != 12'h000) err_o = ERR_RANGE;
      end
      IMM_NONE: begin
        mask_o  = '0;
        value_o = '0;
      end
      default: err_o = ERR_SEL;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes decoded instruction fields into RV32I words and writes them to IMEM at consecutive addresses.
// Latency: 2 cycles from accept to imem_we_o (S1 capture/check, S2 write); 1 word/cycle with grant high.
// Backpressure: S2 holds until imem_gnt_i; S1 stalls behind it; ready_o low when S1 stalled or FULL.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000  // must be 4-byte aligned
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [2:0]                   ImmSel_i,
  input  logic [6:0]                   opcode_i,
  input  logic [4:0]                   rd_i,
  input  logic [4:0]                   rs1_i,
  input  logic [4:0]                   rs2_i,
  input  logic [2:0]                   funct3_i,
  input  logic [6:0]                   funct7_i,
  input  logic [31:0]                  imm_i,
  output logic                         imem_we_o,
  output logic [31:0]                  imem_addr_o,
  output logic [31:0]                  imem_wdata_o,
  input  logic                         imem_gnt_i,
  output logic                         err_o,
  output logic [1:0]                   err_code_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  enc_fields_t     s1_q, s1_d;
  logic            s1_vld_q, s1_vld_d;
  logic            s2_vld_q, s2_vld_d;
  logic [31:0]     s2_addr_q, s2_addr_d;
  logic [31:0]     s2_wdata_q, s2_wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [0:0]      state_q, state_d;

  logic [31:0]     imm_mask;
  logic [31:0]     imm_value;
  err_code_e       imm_err;
  logic [31:0]     base_word;
  logic [31:0]     enc_word;

  logic            s1_reject;
  logic            s1_move;
  logic            s1_free;
  logic            s2_fire;
  logic            room;
  logic            accept;
  logic [CW:0]     next_slot;
  logic [CW:0]     wr_slot;
  enc_fields_t     fields_in;

  assign fields_in = '{imm_sel: ImmSel_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i,
                       rs2: rs2_i, funct3: funct3_i, funct7: funct7_i, imm: imm_i};

  imm_pack u_imm_pack (
    .imm_sel_i (s1_q.imm_sel),
    .imm_i     (s1_q.imm),
    .mask_o    (imm_mask),
    .value_o   (imm_value),
    .err_o     (imm_err)
  );

  // Place register/funct fields used by the captured format; unused fields stay zero.
  always_comb begin
    base_word      = '0;
    base_word[6:0] = s1_q.opcode;
    case (s1_q.imm_sel)
      IMM_I: begin
        base_word[19:15] = s1_q.rs1;
        base_word[14:12] = s1_q.funct3;
        base_word[11:7]  = s1_q.rd;
      end
      IMM_S, IMM_B: begin
        base_word[24:20] = s1_q.rs2;
        base_word[19:15] = s1_q.rs1;
        base_word[14:12] = s1_q.funct3;
      end
      IMM_J, IMM_U: begin
        base_word[11:7]  = s1_q.rd;
      end
      IMM_NONE: begin
        base_word[31:25] = s1_q.funct7;
        base_word[24:20] = s1_q.rs2;
        base_word[19:15] = s1_q.rs1;
        base_word[14:12] = s1_q.funct3;
        base_word[11:7]  = s1_q.rd;
      end
      default: base_word[6:0] = s1_q.opcode;
    endcase
    enc_word = (base_word & ~imm_mask) | (imm_value & imm_mask);
  end

  // Handshake: an S1 entry needs a free S2 and a remaining IMEM slot, so in-flight words never exceed DEPTH.
  always_comb begin
    s2_fire   = s2_vld_q & imem_gnt_i;
    s1_reject = s1_vld_q & (imm_err != ERR_NONE);
    next_slot = {1'b0, cnt_q} + {{CW{1'b0}}, s2_vld_q};
    room      = (next_slot < (CW+1)'(DEPTH));
    s1_move   = s1_vld_q & ~s1_reject & (~s2_vld_q | imem_gnt_i) & room;
    s1_free   = ~s1_vld_q | s1_reject | s1_move;
    ready_o   = (state_q == ST_LOAD) & s1_free;
    accept    = valid_i & ready_o;
    // Address of a word entering S2 counts the grant happening this same cycle.
    wr_slot   = {1'b0, cnt_q} + {{CW{1'b0}}, s2_fire};
  end

  // Next-state for both pipeline stages, the word counter and the load FSM; start_i wins over everything.
  always_comb begin
    s1_d       = s1_q;
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;
    s2_addr_d  = s2_addr_q;
    s2_wdata_d = s2_wdata_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    if (start_i) begin
      s1_vld_d  = 1'b0;
      s2_vld_d  = 1'b0;
      s2_addr_d = BASE_ADDR;
      cnt_d     = '0;
      state_d   = ST_LOAD;
    end else begin
      if (s2_fire) begin
        cnt_d    = cnt_q + CW'(1);
        s2_vld_d = 1'b0;
      end
      if (s1_move) begin
        s2_vld_d   = 1'b1;
        s2_addr_d  = BASE_ADDR + (32'(wr_slot) << 2);
        s2_wdata_d = enc_word;
      end
      if (s1_free) begin
        s1_vld_d = accept;
        if (accept) s1_d = fields_in;
      end
      if ({1'b0, cnt_d} == (CW+1)'(DEPTH)) state_d = ST_FULL;
    end
  end

  // Register update with synchronous reset; a reset mid-write simply drops S2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_addr_q  <= BASE_ADDR;
      s2_wdata_q <= '0;
      cnt_q      <= '0;
      state_q    <= ST_LOAD;
    end else begin
      s1_q       <= s1_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s2_addr_q  <= s2_addr_d;
      s2_wdata_q <= s2_wdata_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign imem_we_o    = s2_vld_q;
  assign imem_addr_o  = s2_addr_q;
  assign imem_wdata_o = s2_wdata_q;
  // A rejected entry occupies S1 for exactly one cycle, so this is a single-cycle pulse.
  assign err_o        = s1_reject;
  assign err_code_o   = s1_reject ? imm_err : ERR_NONE;
  assign full_o       = (state_q == ST_FULL);
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected IMEM writes plus per-feature checks.
// Latency: n/a.
// Backpressure: exercised by holding imem_gnt_i low.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_i, start_i, valid_i, ready_o, imem_gnt_i;
  logic [2:0]  sel_i, funct3_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i;
  logic        imem_we_o, err_o, full_o;
  logic [31:0] imem_addr_o, imem_wdata_o;
  logic [1:0]  err_code_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [63:0] sb_q[$];
  int          wr_cyc[$];

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
    .ImmSel_i(sel_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .imem_gnt_i(imem_gnt_i), .err_o(err_o), .err_code_o(err_code_o),
    .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every granted write is compared against the oldest expected {addr, data}.
  always @(negedge clk) begin
    logic [63:0] exp_w;
    if (!rst_i && !start_i && imem_we_o && imem_gnt_i) begin
      n_cmp++;
      wr_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got addr=%h data=%h, required no write", imem_addr_o, imem_wdata_o);
      end else begin
        exp_w = sb_q.pop_front();
        if ({imem_addr_o, imem_wdata_o} !== exp_w) begin
          n_err++;
          $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr_o, imem_wdata_o, exp_w[63:32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [2:0] s, input logic [6:0] opc, input logic [4:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im);
    bit done = 0;
    int waited = 0;
    sel_i = s; opcode_i = opc; rd_i = d; rs1_i = r1; rs2_i = r2;
    funct3_i = f3; funct7_i = f7; imm_i = im; valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (ready_o) done = 1;
      @(posedge clk); #1;
      if (!done) begin
        waited++;
        if (waited > 50) begin
          n_cmp++; n_err++;
          $display("FAIL send_accept_timeout: ready_o=%b for 50 cycles, required 1", ready_o);
          done = 1;
        end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d writes still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; imem_gnt_i = 1'b0;
    sel_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
    funct3_i = '0; funct7_i = '0; imm_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b, required 0", imem_we_o); end
    n_cmp++; if (imem_addr_o !== BASE) begin n_err++; $display("FAIL reset_addr: got %h, required %h", imem_addr_o, BASE); end
    n_cmp++; if (imem_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h, required 0", imem_wdata_o); end
    n_cmp++; if ({err_o, err_code_o} !== 3'b000) begin n_err++; $display("FAIL reset_err: got %b/%b, required 0/00", err_o, err_code_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b, required 0", full_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", count_o); end
    rst_i = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
  endtask

  task automatic test_u_j();
    imem_gnt_i = 1'b1;
    sb_q.push_back({BASE, 32'h0000_42B7});
    send(3'b100, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_4000);
    sb_q.push_back({BASE + 32'd4, 32'h0080_056F});
    send(3'b011, OP_JAL, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    wait_drain();
    n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL uj_count: got %0d, required 2", count_o); end
  endtask

  task automatic test_b_s_i();
    imem_gnt_i = 1'b1;
    sb_q.push_back({BASE, 32'h013A_0663});
    send(3'b010, OP_BR, 5'd0, 5'd20, 5'd19, 3'b000, 7'd0, 32'd12);
    sb_q.push_back({BASE + 32'd4, 32'h0091_2223});
    send(3'b001, OP_ST, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd4);
    sb_q.push_back({BASE + 32'd8, 32'hFFB8_8D13});
    send(3'b000, OP_IMM, 5'd26, 5'd17, 5'd0, 3'b000, 7'd0, -32'sd5);
    wait_drain();
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL bsi_count: got %0d, required 3", count_o); end
  endtask

  task automatic test_back_to_back();
    imem_gnt_i = 1'b1;
    wr_cyc.delete();
    // R-type with a garbage immediate: imm must not leak into the word.
    sb_q.push_back({BASE, 32'h4020_81B3});
    send(3'b111, OP_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'hFFFF_FFFF);
    sb_q.push_back({BASE + 32'd4, 32'h0000_42B7});
    send(3'b100, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_4000);
    sb_q.push_back({BASE + 32'd8, 32'hFFB8_8D13});
    send(3'b000, OP_IMM, 5'd26, 5'd17, 5'd0, 3'b000, 7'd0, -32'sd5);
    wait_drain();
    n_cmp++;
    if (wr_cyc.size() != 3) begin
      n_err++; $display("FAIL b2b_writes: got %0d writes, required 3", wr_cyc.size());
    end else if (wr_cyc[1] - wr_cyc[0] != 1 || wr_cyc[2] - wr_cyc[1] != 1) begin
      n_err++; $display("FAIL b2b_spacing: got gaps %0d,%0d, required 1,1", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
    end
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL b2b_count: got %0d, required 3", count_o); end
  endtask

  task automatic test_backpressure();
    imem_gnt_i = 1'b0;
    sb_q.push_back({BASE, 32'h013A_0663});
    send(3'b010, OP_BR, 5'd0, 5'd20, 5'd19, 3'b000, 7'd0, 32'd12);
    sb_q.push_back({BASE + 32'd4, 32'h0091_2223});
    send(3'b001, OP_ST, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_we_o, imem_addr_o, imem_wdata_o} !== {1'b1, BASE, 32'h013A_0663}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got we=%b addr=%h data=%h, required we=1 addr=%h data=013a0663",
                 i, imem_we_o, imem_addr_o, imem_wdata_o, BASE);
      end
      n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b, required 0", i, ready_o); end
    end
    @(posedge clk); #1;
    imem_gnt_i = 1'b1;
    sb_q.push_back({BASE + 32'd8, 32'hFFB8_8D13});
    send(3'b000, OP_IMM, 5'd26, 5'd17, 5'd0, 3'b000, 7'd0, -32'sd5);
    wait_drain();
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL bp_count: got %0d, required 3", count_o); end
  endtask

  task automatic test_errors();
    logic [2:0]  e_sel  [3] = '{3'b010, 3'b000, 3'b101};
    logic [31:0] e_imm  [3] = '{32'd7, 32'd2048, 32'd0};
    logic [1:0]  e_code [3] = '{2'b10, 2'b01, 2'b11};
    bit seen;
    imem_gnt_i = 1'b1;
    sb_q.push_back({BASE, 32'h0000_42B7});
    send(3'b100, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_4000);
    wait_drain();
    for (int k = 0; k < 3; k++) begin
      send(e_sel[k], OP_IMM, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, e_imm[k]);
      seen = 0;
      for (int w = 0; w < 4 && !seen; w++) begin
        if (err_o === 1'b1) seen = 1;
        else begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (!seen) begin
        n_err++; $display("FAIL err_pulse[%0d]: err_o never rose, required 1", k);
      end else begin
        n_cmp++;
        if (err_code_o !== e_code[k]) begin n_err++; $display("FAIL err_code[%0d]: got %b, required %b", k, err_code_o, e_code[k]); end
        @(posedge clk); #1;
        n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL err_width[%0d]: got %b a cycle later, required 0", k, err_o); end
      end
      n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL err_count[%0d]: got %0d, required 1", k, count_o); end
    end
    sb_q.push_back({BASE + 32'd4, 32'hFFB8_8D13});
    send(3'b000, OP_IMM, 5'd26, 5'd17, 5'd0, 3'b000, 7'd0, -32'sd5);
    wait_drain();
    n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL err_after_count: got %0d, required 2", count_o); end
  endtask

  task automatic test_full_restart();
    imem_gnt_i = 1'b1;
    sb_q.push_back({BASE, 32'h0000_42B7});
    send(3'b100, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_4000);
    sb_q.push_back({BASE + 32'd4, 32'h0080_056F});
    send(3'b011, OP_JAL, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    sb_q.push_back({BASE + 32'd8, 32'h013A_0663});
    send(3'b010, OP_BR, 5'd0, 5'd20, 5'd19, 3'b000, 7'd0, 32'd12);
    sb_q.push_back({BASE + 32'd12, 32'h0091_2223});
    send(3'b001, OP_ST, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd4);
    wait_drain();
    n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d, required 4", count_o); end
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b, required 1", full_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b, required 0", ready_o); end
    // start_i with valid_i while FULL.
    sel_i = 3'b000; opcode_i = OP_IMM; rd_i = 5'd26; rs1_i = 5'd17; imm_i = -32'sd5;
    valid_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL restart_count: got %0d, required 0", count_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL restart_full: got %b, required 0", full_o); end
    // start_i with valid_i while LOAD and ready: the input must be dropped.
    valid_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL restart_drop: count got %0d, required 0", count_o); end
    sb_q.push_back({BASE, 32'hFFB8_8D13});
    send(3'b000, OP_IMM, 5'd26, 5'd17, 5'd0, 3'b000, 7'd0, -32'sd5);
    wait_drain();
    n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL restart_next: count got %0d, required 1", count_o); end
  endtask

  initial begin
    test_reset();
    test_u_j();
    do_start();
    test_b_s_i();
    do_start();
    test_back_to_back();
    do_start();
    test_backpressure();
    do_start();
    test_errors();
    do_start();
    test_full_restart();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL end_pending: got %0d writes outstanding, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and instruction-memory loader: the inverse of the immediate generator. It takes decoded fields (opcode, registers, funct3/funct7, a signed 32-bit immediate and an ImmSel type) over a valid/ready handshake. It range-checks and scatters the immediate into RV32I bit positions, then writes the assembled 32-bit word into instruction memory at consecutive word addresses. It feeds the IMEM write port from the debug/boot loader path.

## Interface
- DEPTH, 1024: number of IMEM words the loader may write before reporting full.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be 4-byte aligned.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse: restart the load at BASE_ADDR, drop all in-flight entries, clear full_o.
- valid_i  in  1  input fields valid.
- ready_o  out  1  encoder can accept this cycle.
- ImmSel_i  in  3  I=000, S=001, B=010, J=011, U=100, NONE(R-type)=111; 101/110 are illegal.
- opcode_i  in  7  opcode, copied to inst[6:0].
- rd_i, rs1_i, rs2_i  in  5 each  register indices.
- funct3_i  in  3  copied to inst[14:12] for I/S/B/NONE.
- funct7_i  in  7  copied to inst[31:25] for NONE only.
- imm_i  in  32  signed immediate; for U this is the full value, with the upper 20 bits significant.
- imem_we_o  out  1  write request.
- imem_addr_o  out  32  byte address of the write.
- imem_wdata_o  out  32  encoded instruction.
- imem_gnt_i  in  1  memory accepted the write this cycle.
- err_o  out  1  one-cycle pulse: instruction rejected.
- err_code_o  out  2  01 range, 10 misaligned, 11 illegal ImmSel; valid while err_o is high.
- full_o  out  1  DEPTH words written.
- count_o  out  $clog2(DEPTH+1)  words written since reset/start.

## Operation
- Two-stage pipeline:
  - S1 captures the fields on accept.
  - S2 holds the encoded word and drives the IMEM write.
- Field placement:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [11:7]=rd.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0], plus rs2/rs1.
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11], plus rs2/rs1.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
  - U: [31:12]=imm[31:12], [11:7]=rd.
  - NONE: funct7/rs2/rs1/funct3/rd; imm is ignored.
- Unused fields are not placed, so they cannot corrupt the word.
- Checks, evaluated in S1 on the captured value:
  - I/S: imm in [-2048, 2047], else range error.
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - B/J alignment failure reports misaligned (10); an out-of-range aligned value reports range (01).
  - Illegal ImmSel reports 11.
- A rejected entry leaves S1 without entering S2: err_o pulses, and address and count do not advance.
- Load FSM states:
  - LOAD: accepting.
  - FULL: count_o == DEPTH; ready_o=0, further input stalls.
  - start_i returns to LOAD from either state.
- Address: imem_addr_o = BASE_ADDR + 4*count_o at the time the word enters S2. count_o increments on imem_we_o & imem_gnt_i.

## Timing
- Reset values (asserted at the clock edge with rst_i high):
  - imem_we_o=0, imem_addr_o=BASE_ADDR, imem_wdata_o=0.
  - err_o=0, err_code_o=0, full_o=0, count_o=0, pipeline empty.
  - ready_o=1 in the first cycle after reset deasserts.
- Accept occurs on an edge where valid_i & ready_o. The word is in S2, with imem_we_o high, from the 2nd edge after accept. Minimum latency is 2 cycles; throughput is 1 word per cycle while imem_gnt_i stays high.
- S2 holds imem_we_o/addr/wdata stable until imem_gnt_i is sampled high; S1 stalls behind it.
- ready_o = LOAD & (!S1_valid | S1 advances). S1 advances when S2 is empty, S2 is being granted this cycle, or S1 is rejecting.
- An error is reported the edge after accept; err_o is high for exactly 1 cycle.
- full_o rises the cycle after the DEPTH-th grant.
- start_i has priority over a simultaneous accept or grant: that accept is dropped, a grant in the same cycle does not count, and count_o=0.
- rst_i mid-write drops the pending write with no partial state.

## Structure
- riscv_pkg holds:
  - ImmSel codes (I/S/B/J/U/NONE).
  - Opcode constants.
  - err_code enum.
  - Immediate range limits.
- Sub-module imm_pack: purely combinational field placement plus range/alignment check. Inputs are ImmSel and imm; outputs are a 32-bit scatter mask/value and an error code. The pipeline, FSM and counters live in instr_encoder.

## Test plan
- U and J placement:
  - lui x5, imm=0x4000 (opcode 0110111, rd=5) -> wdata 0x000042B7 at BASE_ADDR.
  - Next, jal x10, 8 -> 0x0080056F at BASE_ADDR+4.
- B placement: beq x20,x19,12 -> 0x013A0663.
- S placement: sw x9,4(x2) -> 0x00912223.
- Sign extension: addi x26,x17,-5 -> 0xFFB88D13.
- Back-to-back throughput and backpressure:
  - Back-to-back valid_i with gnt tied high -> one write per cycle.
  - Hold imem_gnt_i=0 for 3 cycles -> imem_we_o/addr/wdata held stable, ready_o drops, no entry lost.
- Errors:
  - B imm=7 -> err_o pulse with code 10.
  - I imm=2048 -> err_o pulse with code 01.
  - ImmSel=101 -> err_o pulse with code 11.
  - In all three cases count_o and address are unchanged.
- Full and restart:
  - With DEPTH=4, after 4 grants full_o=1 and ready_o=0.
  - Pulse start_i together with valid_i -> count_o=0, the input is dropped, the next write goes to BASE_ADDR.
